// File: rtl/pulse_sync_pkg.sv
// Shared types and parameter defaults for the toggle-handshake pulse transmitter.
package pulse_sync_pkg;

  localparam int unsigned CH_DEF          = 4;
  localparam int unsigned CNT_W_DEF       = 3;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ch_state_e;

endpackage

// File: rtl/pulse_tx_ch.sv
// One pulse channel: ack synchroniser, IDLE/WAIT handshake FSM, saturating
// pending-pulse counter and sticky overflow flag.
module pulse_tx_ch
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_en,
  input  logic             ovf_clr,
  input  logic             ack_tgl,
  output logic             req_tgl,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ch_state_e              state_q, state_d;
  logic                   req_q, req_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   launch;
  logic                   drop;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~ovf_clr;
    launch  = 1'b0;
    drop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0 || din_en) begin
          launch  = 1'b1;
          req_d   = ~req_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ack level matching our request level means the remote side caught up.
        if (ack_s == req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (din_en && !launch) begin
      if (cnt_q == CNT_MAX) drop = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (!din_en && launch) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_tgl};
    end
  end

  assign req_tgl  = req_q;
  assign pend_cnt = cnt_q;
  assign busy     = (state_q == WAIT);
  assign overflow = ovf_q;

endmodule

// File: rtl/pulse_sync_tx.sv
// Multi-channel pulse transmitter: CH independent toggle-handshake channels.
module pulse_sync_tx
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CH          = CH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       din_en,
  input  logic [CH-1:0]       ovf_clr,
  input  logic [CH-1:0]       ack_tgl,
  output logic [CH-1:0]       req_tgl,
  output logic [CH*CNT_W-1:0] pend_cnt,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       overflow
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pulse_tx_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .din_en  (din_en[g]),
      .ovf_clr (ovf_clr[g]),
      .ack_tgl (ack_tgl[g]),
      .req_tgl (req_tgl[g]),
      .pend_cnt(pend_cnt[g*CNT_W +: CNT_W]),
      .busy    (busy[g]),
      .overflow(overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_sync_tx.sv
// Directed + random bench for pulse_sync_tx with a delayed-echo ack model and
// a per-channel toggle scoreboard.
module tb_pulse_sync_tx;

  localparam int CH    = 4;
  localparam int CNT_W = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH-1:0]       din_en  = '0;
  logic [CH-1:0]       ovf_clr = '0;
  logic [CH-1:0]       ack_tgl;
  logic [CH-1:0]       req_tgl;
  logic [CH*CNT_W-1:0] pend_cnt;
  logic [CH-1:0]       busy;
  logic [CH-1:0]       overflow;

  pulse_sync_tx #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .din_en  (din_en),
    .ovf_clr (ovf_clr),
    .ack_tgl (ack_tgl),
    .req_tgl (req_tgl),
    .pend_cnt(pend_cnt),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Remote side: echoes req_tgl after dly cycles; ack_hold freezes it.
  logic [CH-1:0] pipe [16];
  int            dly = 5;
  logic          ack_hold = 1'b0;
  assign ack_tgl = pipe[dly-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pipe[i] <= '0;
    end else if (!ack_hold) begin
      pipe[0] <= req_tgl;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  end

  typedef struct {
    int   ch;
    logic lvl;
  } sb_t;

  sb_t           sb [$];
  logic [CH-1:0] exp_lvl = '0;
  logic [CH-1:0] prev_req = '0;
  logic          rst_at_edge;
  int            sent [CH];
  int            drops [CH];
  int            toggles [CH];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] pend(input int c);
    return pend_cnt[c*CNT_W +: CNT_W];
  endfunction

  function automatic int sb_count(input int c);
    int n = 0;
    foreach (sb[k]) if (sb[k].ch == c) n++;
    return n;
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  // Monitor: every req_tgl edge must consume the oldest expected entry of its channel.
  always @(negedge clk) begin
    if (rst_at_edge === 1'b1) begin
      sb.delete();
      exp_lvl  = '0;
      prev_req = req_tgl;
      for (int c = 0; c < CH; c++) begin
        sent[c] = 0; drops[c] = 0; toggles[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (req_tgl[c] !== prev_req[c]) begin
          logic found;
          found = 1'b0;
          toggles[c]++;
          for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].ch == c) begin
              check($sformatf("toggle_lvl_ch%0d", c), {31'd0, req_tgl[c]}, {31'd0, sb[k].lvl});
              sb.delete(k);
              found = 1'b1;
              break;
            end
          end
          if (!found) check($sformatf("unexpected_toggle_ch%0d", c), {31'd0, found}, 32'd1);
        end
      end
      prev_req = req_tgl;
    end
  end

  // Drive one cycle of stimulus; pulses in drop_mask are the ones the test expects to be lost.
  task automatic drive(input logic [CH-1:0] en, input logic [CH-1:0] clr,
                       input logic [CH-1:0] drop_mask);
    for (int c = 0; c < CH; c++) begin
      if (en[c] && !rst) begin
        sent[c]++;
        if (drop_mask[c]) drops[c]++;
        else begin
          exp_lvl[c] = ~exp_lvl[c];
          sb.push_back('{ch: c, lvl: exp_lvl[c]});
        end
      end
    end
    din_en  = en;
    ovf_clr = clr;
    @(posedge clk); #1;
    din_en  = '0;
    ovf_clr = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy !== '0 || pend_cnt !== '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < budget}, 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req",  {28'd0, req_tgl},  32'd0);
    check("rst_pend", {20'd0, pend_cnt}, 32'd0);
    check("rst_busy", {28'd0, busy},     32'd0);
    check("rst_ovf",  {28'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single pulse on ch0: toggle next cycle, busy drops 5+2+1 cycles later
    drive(4'b0001, '0, '0);
    @(negedge clk);
    check("single_req",  {31'd0, req_tgl[0]}, 32'd1);
    check("single_busy", {31'd0, busy[0]},    32'd1);
    check("single_pend", {29'd0, pend(0)},    32'd0);
    n = 0;
    while (busy[0] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("single_busy_latency", n, 32'd8);
    wait_idle("single_idle", 100);

    // Burst of 4 on ch1
    repeat (4) drive(4'b0010, '0, '0);
    @(negedge clk);
    check("burst_pend_peak", {29'd0, pend(1)}, 32'd3);
    wait_idle("burst_idle", 300);
    check("burst_toggles", toggles[1], 32'd4);
    check("burst_sb_empty", sb_count(1), 32'd0);
    check("burst_busy", {31'd0, busy[1]}, 32'd0);

    // Overflow on ch2 with ack held
    ack_hold = 1'b1;
    repeat (8) drive(4'b0100, '0, '0);
    @(negedge clk);
    check("ovf_pend_sat", {29'd0, pend(2)},     32'd7);
    check("ovf_not_yet",  {31'd0, overflow[2]}, 32'd0);
    drive(4'b0100, '0, 4'b0100);
    @(negedge clk);
    check("ovf_set",      {31'd0, overflow[2]}, 32'd1);
    check("ovf_pend_hold", {29'd0, pend(2)},    32'd7);
    check("ovf_other_ch", {28'd0, overflow & 4'b1011}, 32'd0);
    drive('0, 4'b0100, '0);
    @(negedge clk);
    check("ovf_clr", {31'd0, overflow[2]}, 32'd0);
    drive(4'b0100, 4'b0100, 4'b0100);
    @(negedge clk);
    check("ovf_set_wins", {31'd0, overflow[2]}, 32'd1);
    check("ovf_collide_pend", {29'd0, pend(2)}, 32'd7);
    drive('0, 4'b0100, '0);
    ack_hold = 1'b0;
    wait_idle("ovf_drain_idle", 400);
    check("ovf_sb_empty", sb_count(2), 32'd0);
    check("ovf_conserve", toggles[2] + drops[2], sent[2]);
    check("ovf_toggles", toggles[2], 32'd8);

    // Reset while ch3 is in WAIT with two pulses pending; din_en during reset is discarded
    repeat (3) drive(4'b1000, '0, '0);
    @(negedge clk);
    check("mid_busy", {31'd0, busy[3]}, 32'd1);
    check("mid_pend", {29'd0, pend(3)}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    din_en = 4'b1000;
    @(posedge clk); #1;
    rst = 1'b0;
    din_en = '0;
    @(negedge clk);
    check("rstw_req",  {31'd0, req_tgl[3]}, 32'd0);
    check("rstw_pend", {20'd0, pend_cnt},   32'd0);
    check("rstw_busy", {28'd0, busy},       32'd0);
    check("rstw_ovf",  {28'd0, overflow},   32'd0);
    repeat (16) @(negedge clk);
    check("rstw_quiet", {28'd0, busy | req_tgl}, 32'd0);

    // Random patterns with random ack delay
    for (int p = 0; p < 20; p++) begin
      dly = $urandom_range(3, 12);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) drive(CH'($urandom_range(0, 15)), '0, '0);
      wait_idle($sformatf("rand_idle_%0d", p), 400);
      repeat (16) @(negedge clk);
    end
    for (int c = 0; c < CH; c++) begin
      check($sformatf("rand_conserve_ch%0d", c), toggles[c] + drops[c], sent[c]);
      check($sformatf("rand_sb_empty_ch%0d", c), sb_count(c), 32'd0);
    end
    check("rand_ovf", {28'd0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_sync_tx.md
PULSE_SYNC_TX -- requirements
Module: pulse_sync_tx

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent pulse channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 3, width of each per-channel pending-pulse counter (2..8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop stages on each ack_tgl input (2..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din_en  input  CH  single-cycle source pulse per channel; each high cycle is one event.
REQ-007 SHALL have port ovf_clr  input  CH  write-1-to-clear for overflow, per channel.
REQ-008 SHALL have port ack_tgl  input  CH  toggle acknowledge from the remote domain; asynchronous to clk.
REQ-009 SHALL have port req_tgl  output  CH  toggle request to the remote domain, one flop output per channel.
REQ-010 SHALL have port pend_cnt  output  CH*CNT_W  per-channel pending count, channel i at bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port busy  output  CH  high while the channel is in WAIT.
REQ-012 SHALL have port overflow  output  CH  sticky flag: a pulse was dropped.

Function
REQ-013 Channels SHALL be fully independent; no shared state or arbitration.
REQ-014 Each ack_tgl bit SHALL pass through SYNC_STAGES flops in clk before use (ack_s).
REQ-015 Per-channel FSM SHALL have states IDLE and WAIT; busy = (state == WAIT).
REQ-016 launch SHALL be asserted when state == IDLE and (pend_cnt != 0 or din_en).
REQ-017 On launch: req_tgl inverts and state goes to WAIT at the same edge; the new req_tgl is visible one cycle after the din_en cycle.
REQ-018 In WAIT, the state SHALL return to IDLE on the edge where ack_s == req_tgl; no launch occurs in that cycle, and the earliest next launch is the following cycle.
REQ-019 pend_cnt_next SHALL equal pend_cnt + din_en - launch, computed without wrap.
REQ-020 Simultaneous din_en and launch SHALL leave pend_cnt unchanged.
REQ-021 If pend_cnt == 2^CNT_W-1 and din_en and no launch: the pulse is dropped, pend_cnt holds, and overflow sets.
REQ-022 overflow SHALL clear on ovf_clr; when set and clear coincide, set wins.
REQ-023 The number of req_tgl toggles plus dropped pulses SHALL equal the number of din_en cycles, over any interval ending in IDLE with pend_cnt == 0.
REQ-024 ack_tgl changes while in IDLE SHALL be ignored; no state change and no error.

Reset
REQ-025 While rst is high at a clk edge: state = IDLE, req_tgl = 0, pend_cnt = 0, overflow = 0, busy = 0, and all sync flops = 0.
REQ-026 Reset mid-WAIT SHALL abandon the in-flight request (req_tgl returns to 0), and din_en during reset SHALL be discarded.
REQ-027 The remote side SHALL be reset together with this block so that ack_tgl = 0 after reset.

Structure
REQ-028 Package pulse_sync_pkg SHALL hold the FSM state enum (IDLE, WAIT) and the default values for CH, CNT_W and SYNC_STAGES.
REQ-029 One sub-module, pulse_tx_ch (single channel: sync flops, FSM, counter, overflow), SHALL be instantiated CH times via generate.
REQ-030 All outputs SHALL be driven directly from flops; no combinational path from input to output.

Verification (CH=4, CNT_W=3, SYNC_STAGES=2; bench ack model echoes req_tgl after 5 clk cycles)
REQ-031 Single pulse: din_en[0]=1 for one cycle in IDLE -> req_tgl[0] toggles 0->1 on the next cycle, busy[0]=1, pend_cnt ch0 stays 0, and busy[0] drops 5+2+1 cycles later.
REQ-032 Burst: din_en[1]=1 for 4 consecutive cycles -> pend_cnt ch1 reaches 3, then exactly 4 req_tgl[1] toggles in total, ending with pend_cnt=0 and busy=0.
REQ-033 Overflow: hold ack, then 9 pulses on ch2 -> first launches, pend_cnt saturates at 7, 9th dropped, overflow[2]=1; ovf_clr[2] pulse -> overflow[2]=0.
REQ-034 Set/clear collision: ovf_clr[2]=1 in the same cycle as a dropped pulse -> overflow[2] remains 1.
REQ-035 Reset mid-WAIT: rst=1 for 1 cycle while busy[3]=1 and pend_cnt ch3=2 -> next cycle req_tgl[3]=0, pend_cnt=0, busy=0, overflow=0.
REQ-036 Random: 20 random din_en patterns on all channels with a random 3..12 cycle ack delay -> per-channel toggles + drops equal pulses sent, and channels never interfere.
